// File: rtl/acc_delta_decoder.sv
// Rebuilds the original input stream from accumulator samples by modular differencing.
// Recovered values go into a small FWFT FIFO; deltas that are out of range latch err until a resync.
//   state | meaning
//   RUN   | differencing samples and pushing the recovered values
//   ERR   | illegal delta seen; samples are accepted and dropped
//   SYNC  | waiting for a new baseline sample
module acc_delta_decoder #(
    parameter int IN_W  = 4,
    parameter int ACC_W = IN_W + 1,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ACC_W-1:0]         acc_in,
    input  logic                     acc_valid,
    output logic                     acc_ready,
    output logic [IN_W-1:0]          dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     err,
    input  logic                     err_clr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [ACC_W-1:0] MAX_D = ACC_W'((1 << IN_W) - 1);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        ERR  = 2'd1,
        SYNC = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] prev_q, prev_d;
    logic             err_q, err_d;
    logic [IN_W-1:0]  mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q;

    logic             full, empty, accept, pop, push, legal;
    logic [ACC_W-1:0] delta;

    assign empty      = (count_q == '0);
    assign full       = (count_q == CW'(DEPTH));
    // ERR always drains upstream; otherwise backpressure depends only on stored occupancy.
    assign acc_ready  = (state_q == ERR) || !full;
    assign accept     = acc_valid && acc_ready;
    assign pop        = !empty && dout_ready;
    assign delta      = acc_in - prev_q;
    assign legal      = (delta <= MAX_D);
    assign dout       = empty ? '0 : mem_q[rd_ptr_q];
    assign dout_valid = !empty;
    assign err        = err_q;
    assign count      = count_q;

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        err_d   = err_q;
        push    = 1'b0;
        case (state_q)
            RUN: begin
                if (accept) begin
                    if (legal) begin
                        push   = 1'b1;
                        prev_d = acc_in;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end
                end
            end
            ERR: begin
                if (err_clr) begin
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (accept) begin
                    prev_d  = acc_in;
                    err_d   = 1'b0;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            prev_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            err_q   <= err_d;
        end
    end

    // push only happens in RUN, where acc_ready already guarantees a free slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= delta[IN_W-1:0];
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_delta_decoder.sv
// Directed bench for acc_delta_decoder: a reference model pushes expected values into a
// scoreboard queue on every modelled accept, and the head is compared whenever the DUT presents output.
module tb_acc_delta_decoder;

    localparam int IN_W  = 4;
    localparam int ACC_W = 5;
    localparam int DEPTH = 4;

    localparam int S_RUN  = 0;
    localparam int S_ERR  = 1;
    localparam int S_SYNC = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [ACC_W-1:0] acc_in;
    logic             acc_valid;
    logic             acc_ready;
    logic [IN_W-1:0]  dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             err;
    logic             err_clr;
    logic [2:0]       count;

    int tests = 0;
    int fails = 0;

    logic [IN_W-1:0]  sb_q [$];
    int               m_state;
    logic [ACC_W-1:0] m_prev;
    logic             m_err;

    acc_delta_decoder #(.IN_W(IN_W), .ACC_W(ACC_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .acc_in     (acc_in),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .err        (err),
        .err_clr    (err_clr),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_state = S_RUN;
        m_prev  = '0;
        m_err   = 1'b0;
    endtask

    // One clock cycle: drive, compare against the model mid-cycle, advance the model, then clock.
    task automatic cyc(input logic v, input logic [ACC_W-1:0] a, input logic rdy, input logic clr);
        logic             m_ready;
        logic             acc_take;
        logic [ACC_W-1:0] d;
        acc_valid  = v;
        acc_in     = a;
        dout_ready = rdy;
        err_clr    = clr;
        @(negedge clk);
        m_ready = (m_state == S_ERR) || (sb_q.size() < DEPTH);
        chk("acc_ready", 32'(acc_ready), 32'(m_ready));
        chk("dout_valid", 32'(dout_valid), 32'(sb_q.size() != 0));
        chk("count", 32'(count), 32'(sb_q.size()));
        chk("err", 32'(err), 32'(m_err));
        if (sb_q.size() != 0 && rdy) begin
            chk("dout_pop", 32'(dout), 32'(sb_q.pop_front()));
        end else if (sb_q.size() == 0) begin
            chk("dout_empty", 32'(dout), 32'd0);
        end
        acc_take = v && m_ready;
        case (m_state)
            S_RUN: begin
                if (acc_take) begin
                    d = a - m_prev;
                    if (int'(d) <= 15) begin
                        sb_q.push_back(d[IN_W-1:0]);
                        m_prev = a;
                    end else begin
                        m_err   = 1'b1;
                        m_state = S_ERR;
                    end
                end
            end
            S_ERR: begin
                if (clr) m_state = S_SYNC;
            end
            default: begin
                if (acc_take) begin
                    m_prev  = a;
                    m_err   = 1'b0;
                    m_state = S_RUN;
                end
            end
        endcase
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        acc_valid  = 1'b0;
        acc_in     = '0;
        dout_ready = 1'b0;
        err_clr    = 1'b0;
        model_reset();
        #2;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_acc_ready", 32'(acc_ready), 32'd1);
        #10;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // basic differencing, 0 3 7 11 -> 0 3 4 4 with immediate consumption
        cyc(1'b1, 5'd0,  1'b1, 1'b0);
        cyc(1'b1, 5'd3,  1'b1, 1'b0);
        cyc(1'b1, 5'd7,  1'b1, 1'b0);
        cyc(1'b1, 5'd11, 1'b1, 1'b0);
        cyc(1'b0, 5'd0,  1'b1, 1'b0);
        chk("drained", 32'(count), 32'd0);

        // wrap-around: baseline 30 then sample 1 gives 3
        cyc(1'b1, 5'd15, 1'b1, 1'b0);
        cyc(1'b1, 5'd30, 1'b1, 1'b0);
        cyc(1'b1, 5'd1,  1'b1, 1'b0);
        cyc(1'b1, 5'd1,  1'b1, 1'b1);
        cyc(1'b0, 5'd0,  1'b1, 1'b0);

        // backpressure: four accepts fill the FIFO, a pop re-opens it a cycle later
        cyc(1'b1, 5'd2, 1'b0, 1'b0);
        cyc(1'b1, 5'd3, 1'b0, 1'b0);
        cyc(1'b1, 5'd4, 1'b0, 1'b0);
        cyc(1'b1, 5'd5, 1'b0, 1'b0);
        chk("full_count", 32'(count), 32'd4);
        cyc(1'b1, 5'd6, 1'b0, 1'b0);
        cyc(1'b1, 5'd6, 1'b1, 1'b0);
        chk("reopen_ready", 32'(acc_ready), 32'd1);
        cyc(1'b1, 5'd6, 1'b0, 1'b0);
        repeat (5) cyc(1'b0, 5'd0, 1'b1, 1'b0);

        // illegal delta from prev=3, with a concurrent pop
        cyc(1'b1, 5'd21, 1'b0, 1'b0);
        cyc(1'b1, 5'd3,  1'b0, 1'b0);
        cyc(1'b1, 5'd25, 1'b1, 1'b0);
        chk("illegal_err", 32'(err), 32'd1);
        chk("illegal_count", 32'(count), 32'd1);
        cyc(1'b1, 5'd26, 1'b1, 1'b0);
        cyc(1'b1, 5'd27, 1'b0, 1'b0);
        chk("err_discard_count", 32'(count), 32'd0);

        // resync: err_clr pulse, 20 is the baseline, 24 yields 4
        cyc(1'b0, 5'd0,  1'b0, 1'b1);
        chk("sync_err_held", 32'(err), 32'd1);
        cyc(1'b1, 5'd20, 1'b0, 1'b0);
        chk("sync_err_clear", 32'(err), 32'd0);
        chk("sync_no_push", 32'(count), 32'd0);
        cyc(1'b1, 5'd24, 1'b0, 1'b0);
        cyc(1'b0, 5'd0,  1'b1, 1'b0);

        // err_clr together with a discarded sample; next sample is the baseline
        cyc(1'b1, 5'd10, 1'b1, 1'b0);
        cyc(1'b1, 5'd11, 1'b1, 1'b1);
        cyc(1'b1, 5'd0,  1'b1, 1'b0);
        cyc(1'b1, 5'd9,  1'b1, 1'b0);
        cyc(1'b0, 5'd0,  1'b1, 1'b0);

        // async reset with three entries buffered
        cyc(1'b1, 5'd10, 1'b0, 1'b0);
        cyc(1'b1, 5'd11, 1'b0, 1'b0);
        cyc(1'b1, 5'd13, 1'b0, 1'b0);
        chk("pre_reset_count", 32'(count), 32'd3);
        acc_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_count", 32'(count), 32'd0);
        chk("async_dout_valid", 32'(dout_valid), 32'd0);
        chk("async_err", 32'(err), 32'd0);
        chk("async_acc_ready", 32'(acc_ready), 32'd1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b1, 5'd7, 1'b1, 1'b0);
        cyc(1'b0, 5'd0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/acc_delta_decoder.md
# acc_delta_decoder

Receive-side counterpart of the accumulator: consumes the stream of accumulator sums (`acc`, IN_W+1 bits, modulo 2^ACC_W) and reconstructs the original per-cycle input values by modular differencing. Recovered values are buffered in a small first-word-fall-through FIFO with valid/ready backpressure. Deltas that no IN_W-bit input could have produced are flagged as errors, and the decoder resynchronises on request. The block sits between an accumulator output (or a link carrying its samples) and any consumer of the original input stream.

## Interface
- IN_W, 4, width of the original input and of recovered values
- ACC_W, IN_W+1, width of accumulator samples; fixed at IN_W+1
- DEPTH, 4, FIFO entries; must be a power of two and at least 2
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous and active-high; clears all state
- acc_in  in  ACC_W  accumulator sample
- acc_valid  in  1  acc_in is valid this cycle
- acc_ready  out  1  decoder accepts a sample this cycle
- dout  out  IN_W  recovered input value at the FIFO head; 0 when empty
- dout_valid  out  1  FIFO is non-empty
- dout_ready  in  1  consumer pops the head this cycle
- err  out  1  sticky flag for an illegal delta
- err_clr  in  1  leaves the ERR state and starts a resync
- count  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Accept: a sample is taken on any edge where `acc_valid & acc_ready`. The pop condition is `dout_valid & dout_ready`.
- Registers:
  - `prev` (ACC_W bits), the last accepted sample
  - `state` ∈ {RUN, ERR, SYNC}
  - the FIFO storage, read pointer, write pointer and `count`
- Delta: `d = (acc_in - prev) mod 2^ACC_W`.
- Legal delta: `d <= 2^IN_W - 1`.
- RUN, sample accepted:
  - legal d: push `d[IN_W-1:0]` and set `prev <= acc_in`
  - illegal d: no push; set `err <= 1` and move to ERR; `prev` is unchanged
- RUN, other cases:
  - A sample equal to `prev` gives d = 0 and pushes the value 0.
  - `err_clr` is ignored.
- ERR:
  - `acc_ready = 1`; every offered sample is accepted and discarded, so upstream drains.
  - `err_clr = 1` moves to SYNC. `err` stays set until the first sample is accepted in SYNC.
- SYNC:
  - The first accepted sample sets `prev <= acc_in`, clears `err`, moves to RUN, and pushes nothing.
  - `err_clr` in SYNC is ignored.
- acc_ready:
  - RUN or SYNC: `!full`, where full means `count == DEPTH`. A same-cycle pop does not lift backpressure.
  - ERR: 1.
- FIFO pops continue in every state.
- count updates:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged, both pointers advance
- Pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - state = RUN, prev = 0 (this matches the accumulator's reset sum of 0)
  - FIFO empty, count = 0
  - dout = 0, dout_valid = 0, err = 0, acc_ready = 1
- Asserting reset mid-stream flushes the FIFO immediately (asynchronously) and discards all buffered data.
- Latency: a sample accepted at edge N appears on `dout` with `dout_valid = 1` after edge N (visible in cycle N+1). FWFT: `dout` is the head entry, driven combinationally.
- Throughput: one sample per cycle in and one value per cycle out, with no bubbles when the FIFO is neither full nor empty.
- Simultaneous events:
  - An illegal sample and a pop in the same cycle: the pop completes.
  - `err_clr` in the same cycle as a sample accepted in ERR: the sample is discarded and state becomes SYNC. The next accepted sample is the baseline.
- Outputs are registered or decoded from registers. The only combinational paths from inputs to outputs are none.

## Test plan
- Reset release, then samples 0, 3, 7, 11 with dout_ready=1:
  - dout sequence is 0, 3, 4, 4
  - each value appears one cycle after its sample
  - count never exceeds 1
- Wrap-around: baseline 30 (after pushes 15, 15 from 0), then sample 1 → dout = 3, no err.
- Backpressure: dout_ready=0 with samples 1, 2, 3, 4, 5 offered every cycle:
  - acc_ready drops after the 4th accept and count = 4
  - one pop re-raises acc_ready the following cycle
  - the values read out are 1, 1, 1, 1, 1
- Illegal delta: prev=3, sample 25 (d=22):
  - err=1, state ERR, no push
  - samples 26 and 27 are accepted and discarded
- Resync: in ERR, pulse err_clr, then samples 20 and 24:
  - err clears on the 20
  - nothing is pushed for the 20
  - dout=4 for the 24
- Asynchronous reset mid-stream with count=3: rst high between edges gives count=0, dout_valid=0, err=0 and acc_ready=1 immediately.
